// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: state register, wait counter with timeout,
// and the datapath enables/selects that each state drives.
// Ports:
//   clk, reset             - clock and synchronous active-high reset
//   instruction            - IR contents (op = [1:0], func_3 = top 3 bits)
//   zero_flag, mem_ready   - ALU zero result and memory completion
//   pc_write, adr_src, mem_wr, ir_wr, reg_wr      - 1-bit enables/selects
//   result_src, alu_src_a, alu_src_b, imm_src     - 2-bit selects
//   alu_control            - ALU operation
//   curr_state             - registered state
//   illegal_op             - high while in FAULT
module mc_control_unit #(
    parameter int unsigned INSTR_W     = 16,
    parameter bit          MEM_WAIT_EN = 1'b1,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               zero_flag,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_wr,
    output logic               ir_wr,
    output logic               reg_wr,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         imm_src,
    output logic [2:0]         alu_control,
    output logic [3:0]         curr_state,
    output logic               illegal_op
);

    typedef enum logic [3:0] {
        FETCH     = 4'h0,
        DECODE    = 4'h1,
        MEM_ADR   = 4'h2,
        MEM_READ  = 4'h3,
        MEM_WB    = 4'h4,
        MEM_WRITE = 4'h5,
        EXECUTE_R = 4'h6,
        ALU_WB    = 4'h7,
        EXECUTE_I = 4'h8,
        BNEZ      = 4'h9,
        BEQZ      = 4'hA,
        JMP       = 4'hB,
        FAULT     = 4'hF
    } state_t;

    // Counter only needs to reach TIMEOUT-1 before the fault fires.
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST =
        CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          rdy;
    logic          waiting;
    logic          timed_out;
    logic [1:0]    op;
    logic [2:0]    func_3;
    logic          unused_bits;

    assign rdy         = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign op          = instruction[1:0];
    assign func_3      = instruction[INSTR_W-1 -: 3];
    assign unused_bits = ^instruction[INSTR_W-4:2];
    assign curr_state  = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        pc_write     = 1'b0;
        adr_src      = 1'b0;
        mem_wr       = 1'b0;
        ir_wr        = 1'b0;
        reg_wr       = 1'b0;
        result_src   = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        imm_src      = 2'b00;
        alu_control  = 3'b000;
        illegal_op   = 1'b0;
        waiting      = 1'b0;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;

        case (state)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_wr      = rdy;
                pc_write   = rdy;
                waiting    = 1'b1;
                if (rdy) state_nxt = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 2'b10;
                unique case (op)
                    2'b00: state_nxt = EXECUTE_R;
                    2'b01: state_nxt = EXECUTE_I;
                    2'b10: state_nxt = MEM_ADR;
                    2'b11: begin
                        unique case (func_3)
                            3'b000:  state_nxt = BEQZ;
                            3'b001:  state_nxt = BNEZ;
                            3'b010:  state_nxt = JMP;
                            default: state_nxt = FAULT;
                        endcase
                    end
                endcase
            end
            MEM_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = 2'b01;
                state_nxt = func_3[0] ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                adr_src = 1'b1;
                waiting = 1'b1;
                if (rdy) state_nxt = MEM_WB;
            end
            MEM_WB: begin
                result_src = 2'b01;
                reg_wr     = 1'b1;
                state_nxt  = FETCH;
            end
            MEM_WRITE: begin
                adr_src = 1'b1;
                mem_wr  = 1'b1;
                waiting = 1'b1;
                if (rdy) state_nxt = FETCH;
            end
            EXECUTE_R: begin
                alu_src_a   = 2'b10;
                alu_control = func_3;
                state_nxt   = ALU_WB;
            end
            EXECUTE_I: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = func_3;
                state_nxt   = ALU_WB;
            end
            ALU_WB: begin
                reg_wr    = 1'b1;
                state_nxt = FETCH;
            end
            BNEZ, BEQZ: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b11;
                alu_control = 3'b001;
                pc_write    = (state == BEQZ) ? zero_flag : ~zero_flag;
                state_nxt   = FETCH;
            end
            JMP: begin
                pc_write  = 1'b1;
                state_nxt = FETCH;
            end
            // FAULT and the unused encodings are sticky until reset.
            default: begin
                illegal_op = 1'b1;
                state_nxt  = FAULT;
            end
        endcase

        // A ready response in the last allowed cycle still wins.
        timed_out = waiting && !rdy && (TIMEOUT != 0) &&
                    (wait_cnt == TO_LAST);
        if (timed_out) state_nxt = FAULT;

        // Any state change (i.e. entering a wait state) or a
        // completed access restarts the count.
        if ((state_nxt != state) || rdy)
            wait_cnt_nxt = '0;
        else if (waiting && (wait_cnt != '1))
            wait_cnt_nxt = wait_cnt + 1'b1;
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: three configurations share the
// same stimulus and are checked against a per-configuration model.
module tb_mc_control_unit;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instruction = '0;
    logic        zero_flag = 1'b0;
    logic        mem_ready = 1'b1;
    logic [20:0] act [N];

    // Config 0: defaults; 1: short timeout; 2: memory waits ignored.
    int to_arr [N] = '{64, 4, 64};
    bit we_arr [N] = '{1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mc_control_unit #(
            .INSTR_W    (16),
            .MEM_WAIT_EN((g == 2) ? 1'b0 : 1'b1),
            .TIMEOUT    ((g == 1) ? 4 : 64)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .instruction(instruction),
            .zero_flag  (zero_flag),
            .mem_ready  (mem_ready),
            .pc_write   (act[g][20]),
            .adr_src    (act[g][19]),
            .mem_wr     (act[g][18]),
            .ir_wr      (act[g][17]),
            .reg_wr     (act[g][16]),
            .result_src (act[g][15:14]),
            .alu_src_a  (act[g][13:12]),
            .alu_src_b  (act[g][11:10]),
            .imm_src    (act[g][9:8]),
            .alu_control(act[g][7:5]),
            .curr_state (act[g][4:1]),
            .illegal_op (act[g][0])
        );
    end

    typedef struct {
        int               cyc;
        logic [N-1:0][20:0] e;
    } exp_t;

    exp_t q [$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    int   m_st  [N];
    int   m_cnt [N];

    // Expected outputs laid out as:
    // pcw adr mwr irw rwr res[2] a[2] b[2] imm[2] alu[3] st[4] ill
    function automatic logic [20:0] pack(
        bit pcw, bit adr, bit mwr, bit irw, bit rwr,
        int res, int a, int b, int imm, int alu, int st, bit ill);
        logic [20:0] v;
        v = {pcw, adr, mwr, irw, rwr, 2'(res), 2'(a), 2'(b),
             2'(imm), 3'(alu), 4'(st), ill};
        return v;
    endfunction

    // One cycle of the reference behaviour for one configuration.
    task automatic model(input int k, output logic [20:0] o);
        int  st, f3, op, nst;
        bit  mr, zf, wait_st;
        st = m_st[k];
        f3 = int'(instruction[15:13]);
        op = int'(instruction[1:0]);
        zf = zero_flag;
        mr = we_arr[k] ? mem_ready : 1'b1;
        wait_st = (st == 0) || (st == 3) || (st == 5);
        nst = st;
        case (st)
            0: begin
                o = pack(mr, 0, 0, mr, 0, 2, 0, 2, 0, 0, st, 0);
                nst = mr ? 1 : 0;
            end
            1: begin
                o = pack(0, 0, 0, 0, 0, 0, 1, 1, 2, 0, st, 0);
                if (op == 0) nst = 6;
                else if (op == 1) nst = 8;
                else if (op == 2) nst = 2;
                else if (f3 == 0) nst = 10;
                else if (f3 == 1) nst = 9;
                else if (f3 == 2) nst = 11;
                else nst = 15;
            end
            2: begin
                o = pack(0, 0, 0, 0, 0, 0, 2, 1, 1, 0, st, 0);
                nst = (f3 % 2 == 1) ? 5 : 3;
            end
            3: begin
                o = pack(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, st, 0);
                nst = mr ? 4 : 3;
            end
            4: begin
                o = pack(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, st, 0);
                nst = 0;
            end
            5: begin
                o = pack(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, st, 0);
                nst = mr ? 0 : 5;
            end
            6: begin
                o = pack(0, 0, 0, 0, 0, 0, 2, 0, 0, f3, st, 0);
                nst = 7;
            end
            7: begin
                o = pack(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, st, 0);
                nst = 0;
            end
            8: begin
                o = pack(0, 0, 0, 0, 0, 0, 2, 1, 0, f3, st, 0);
                nst = 7;
            end
            9: begin
                o = pack(!zf, 0, 0, 0, 0, 0, 2, 3, 0, 1, st, 0);
                nst = 0;
            end
            10: begin
                o = pack(zf, 0, 0, 0, 0, 0, 2, 3, 0, 1, st, 0);
                nst = 0;
            end
            11: begin
                o = pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, st, 0);
                nst = 0;
            end
            default: begin
                o = pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st, 1);
                nst = 15;
            end
        endcase
        if (wait_st && !mr && to_arr[k] > 0 &&
            m_cnt[k] == to_arr[k] - 1)
            nst = 15;
        if (reset) begin
            m_st[k]  = 0;
            m_cnt[k] = 0;
        end else begin
            if (nst != st || mr) m_cnt[k] = 0;
            else if (wait_st) m_cnt[k] = m_cnt[k] + 1;
            m_st[k] = nst;
        end
    endtask

    task automatic step(input logic [15:0] ins, input bit zf,
                        input bit mr, input bit rst);
        exp_t x;
        logic [20:0] o;
        @(negedge clk);
        instruction = ins;
        zero_flag   = zf;
        mem_ready   = mr;
        reset       = rst;
        x.cyc = cycle;
        for (int k = 0; k < N; k++) begin
            model(k, o);
            x.e[k] = o;
        end
        q.push_back(x);
        cycle++;
    endtask

    function automatic logic [15:0] mk(input int op, input int f3);
        logic [15:0] v;
        v = {3'(f3), 11'($urandom), 2'(op)};
        return v;
    endfunction

    // Monitor: compares whatever the DUTs present against the queue.
    always @(negedge clk) begin
        exp_t x;
        #2;
        if (q.size() > 0) begin
            x = q.pop_front();
            for (int k = 0; k < N; k++) begin
                checks++;
                if (act[k] !== x.e[k]) begin
                    errors++;
                    $display("FAIL cfg%0d cyc %0d: got %h exp %h",
                             k, x.cyc, act[k], x.e[k]);
                end
            end
        end
    end

    initial begin
        logic [15:0] ins;
        for (int k = 0; k < N; k++) begin
            m_st[k]  = 0;
            m_cnt[k] = 0;
        end
        @(posedge clk);
        step(mk(0, 0), 0, 1, 1);
        step(mk(0, 0), 0, 1, 1);

        // R-type, func_3 010
        ins = mk(0, 2);
        repeat (4) step(ins, 0, 1, 0);
        step(ins, 0, 1, 0);

        // Load with three wait cycles in MEM_READ
        step(mk(0, 0), 0, 1, 1);
        ins = mk(2, 0);
        step(ins, 0, 1, 0);
        step(ins, 0, 1, 0);
        step(ins, 0, 1, 0);
        repeat (3) step(ins, 0, 0, 0);
        step(ins, 0, 1, 0);
        step(ins, 0, 1, 0);
        step(ins, 0, 1, 0);

        // Branches with zero_flag low
        step(mk(0, 0), 0, 1, 1);
        ins = mk(3, 1);
        repeat (3) step(ins, 0, 1, 0);
        ins = mk(3, 0);
        repeat (3) step(ins, 0, 1, 0);
        ins = mk(3, 2);
        repeat (3) step(ins, 1, 1, 0);

        // Store stalled: short-timeout config faults, default
        // config is reset mid-wait
        step(mk(0, 0), 0, 1, 1);
        ins = mk(2, 1);
        repeat (3) step(ins, 0, 1, 0);
        repeat (6) step(ins, 0, 0, 0);
        step(ins, 0, 0, 1);
        step(ins, 0, 0, 0);

        // Illegal op is sticky until reset
        step(mk(0, 0), 0, 1, 1);
        ins = mk(3, 7);
        repeat (12) step(ins, 0, 1, 0);
        step(ins, 0, 1, 1);
        step(ins, 0, 1, 0);

        // Long fetch stall reaches the default timeout
        step(mk(0, 0), 0, 1, 1);
        repeat (70) step(mk(0, 0), 0, 0, 0);
        step(mk(0, 0), 0, 1, 1);

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            step(16'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 59) == 0));
        end

        step(mk(0, 0), 0, 1, 1);
        @(negedge clk);
        #4;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending exp 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter INSTR_W, 16: instruction width; SHALL be >= 8.
REQ-002 Parameter MEM_WAIT_EN, 1: 1 honours mem_ready; 0 treats mem_ready as constant 1.
REQ-003 Parameter TIMEOUT, 64: maximum consecutive mem_ready-low cycles in a wait state; 0 disables the timeout.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 instruction  in  INSTR_W  current IR contents; op = [1:0], func_3 = [INSTR_W-1:INSTR_W-3].
REQ-007 zero_flag  in  1  ALU zero result.
REQ-008 mem_ready  in  1  memory access completes this cycle.
REQ-009 pc_write, adr_src, mem_wr, ir_wr, reg_wr  out  1 each  datapath enables and selects.
REQ-010 result_src, alu_src_a, alu_src_b, imm_src  out  2 each  datapath selects.
REQ-011 alu_control  out  3  ALU operation.
REQ-012 curr_state  out  4  registered state.
REQ-013 illegal_op  out  1  high while in FAULT.

Function
REQ-014 State encodings SHALL be: FETCH 0, DECODE 1, MEM_ADR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE_R 6, ALU_WB 7, EXECUTE_I 8, BNEZ 9, BEQZ A, JMP B, FAULT F.
REQ-015 All outputs SHALL be combinational from curr_state, instruction, zero_flag, mem_ready; any unlisted output in a state SHALL be 0.
REQ-016 FETCH: alu_src_a=00, alu_src_b=10, result_src=10, ir_wr=pc_write=mem_ready; next DECODE if mem_ready, else stay.
REQ-017 DECODE: alu_src_a=01, alu_src_b=01, imm_src=10. Next: op 00 EXECUTE_R; 01 EXECUTE_I; 10 MEM_ADR; 11 with func_3 000 BEQZ, 001 BNEZ, 010 JMP, otherwise FAULT.
REQ-018 MEM_ADR: alu_src_a=10, alu_src_b=01, imm_src=01; next MEM_READ if func_3[0]=0, else MEM_WRITE.
REQ-019 MEM_READ: adr_src=1; next MEM_WB when mem_ready, else stay.
REQ-020 MEM_WB: result_src=01, reg_wr=1; next FETCH.
REQ-021 MEM_WRITE: adr_src=1, mem_wr=1 every cycle in the state; next FETCH when mem_ready, else stay.
REQ-022 EXECUTE_R: alu_src_a=10, alu_src_b=00, alu_control=func_3. EXECUTE_I: alu_src_a=10, alu_src_b=01, imm_src=00, alu_control=func_3. Both go next to ALU_WB.
REQ-023 ALU_WB: result_src=00, reg_wr=1; next FETCH.
REQ-024 BNEZ/BEQZ: alu_src_a=10, alu_src_b=11, alu_control=001, result_src=00; pc_write = ~zero_flag (BNEZ) or zero_flag (BEQZ); next FETCH.
REQ-025 JMP: result_src=00, pc_write=1; next FETCH.
REQ-026 alu_control SHALL be 000 in every state not named in REQ-022/024.
REQ-027 FAULT: all enables 0, illegal_op=1; next FAULT until reset.
REQ-028 Any unused encoding (C, D, E) SHALL drive outputs as FAULT and go next to FAULT.
REQ-029 Wait counter: clears on entering FETCH, MEM_READ or MEM_WRITE and whenever mem_ready=1; otherwise increments by 1 per wait cycle, saturating.
REQ-030 With TIMEOUT>0, when the counter equals TIMEOUT-1 and mem_ready=0 in a wait state, next state SHALL be FAULT; mem_ready=1 in that same cycle takes priority.
REQ-031 With MEM_WAIT_EN=0, no wait state SHALL last more than 1 cycle and the timeout SHALL never fire.

Reset
REQ-032 reset=1 at a clock edge SHALL set curr_state=FETCH and the wait counter to 0, overriding any transition, including from FAULT or mid-wait.
REQ-033 After reset, outputs SHALL match the FETCH row; illegal_op SHALL be 0.

Verification
REQ-034 R-type (op 00, func_3 010), mem_ready=1: sequence 0,1,6,7,0; alu_control=010 in state 6; reg_wr=1 only in state 7.
REQ-035 Load with mem_ready low for 3 cycles in MEM_READ: state 3 held for 4 cycles, then 4 then 0; reg_wr pulses once.
REQ-036 BNEZ with zero_flag=0: pc_write=1 in state 9. BEQZ with zero_flag=0: pc_write=0 in state A.
REQ-037 op 11, func_3 111: state F; illegal_op=1; state stays F for 10 cycles; reset returns to 0.
REQ-038 TIMEOUT=4, store with mem_ready held 0: mem_wr=1 for 4 cycles in state 5, then state F.
REQ-039 reset asserted in MEM_WRITE mid-wait: next state 0, mem_wr=0.
